// File: rtl/capture_sequencer.sv
// rtl/capture_sequencer.sv - capture/readback sequencer for the 8-channel logic analyser
//
// Purpose: generates the sample strobe, evaluates the masked trigger, counts
// post-trigger samples and addresses the capture BRAM for writing. After the
// last write it reads the whole buffer back newest-first and feeds each byte
// to the UART transmitter.
//
// Ports:
//   CAP_CLK     sampling/system clock
//   RST         asynchronous active-high reset
//   CAP         synchronised channel inputs
//   arm/abort   one-cycle start / cancel pulses from the command decoder
//   div         sample period minus 1 (CAP_CLK cycles)
//   trig_mask   channels taking part in the trigger
//   trig_value  required level of each masked channel
//   delay_cnt   samples written after the trigger sample
//   wr_addr/wr_ce  BRAM write port control
//   rd_addr/rd_ce  BRAM read port control (1-cycle read latency)
//   tx_start/tx_busy  UART transmitter handshake
//   tx_own      high while this block drives the UART data mux
//   running     high in any state except IDLE
//   done        one-cycle pulse when readback completes
module capture_sequencer #(
    parameter int ADDR_W = 13,
    parameter int DIV_W  = 24,
    parameter int CH     = 8
) (
    input  logic              CAP_CLK,
    input  logic              RST,
    input  logic [CH-1:0]     CAP,
    input  logic              arm,
    input  logic              abort,
    input  logic [DIV_W-1:0]  div,
    input  logic [CH-1:0]     trig_mask,
    input  logic [CH-1:0]     trig_value,
    input  logic [ADDR_W-1:0] delay_cnt,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_ce,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ce,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              tx_own,
    output logic              running,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE, S_ARMED, S_POST, S_RD_ISSUE, S_RD_WAIT, S_TX_REQ, S_TX_BUSY, S_TX_DONE
    } state_t;

    // Value of the sent counter just before the final byte completes.
    localparam logic [ADDR_W:0] LAST_SENT = {1'b0, {ADDR_W{1'b1}}};

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [CH-1:0]     mask_q, mask_d;
    logic [CH-1:0]     value_q, value_d;
    logic [ADDR_W-1:0] delay_q, delay_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] remaining_q, remaining_d;
    logic [ADDR_W:0]   sent_q, sent_d;
    logic              started_q, started_d;

    logic sampling;
    logic strobe;
    logic hit;

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        mask_d      = mask_q;
        value_d     = value_q;
        delay_d     = delay_q;
        div_cnt_d   = div_cnt_q;
        wr_addr_d   = wr_addr_q;
        rd_addr_d   = rd_addr_q;
        remaining_d = remaining_q;
        sent_d      = sent_q;
        started_d   = started_q;
        wr_ce       = 1'b0;
        rd_ce       = 1'b0;
        tx_start    = 1'b0;
        tx_own      = 1'b0;
        done        = 1'b0;
        running     = (state_q != S_IDLE);

        sampling = (state_q == S_ARMED) || (state_q == S_POST);
        // abort wins over a coincident strobe: nothing is written that cycle.
        strobe   = sampling && (div_cnt_q == div_q) && !abort;
        hit      = ((CAP ^ value_q) & mask_q) == '0;

        if (sampling) begin
            div_cnt_d = strobe ? '0 : div_cnt_q + 1'b1;
        end
        if (strobe) begin
            wr_ce     = 1'b1;
            wr_addr_d = wr_addr_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (arm && !abort) begin
                    state_d   = S_ARMED;
                    wr_addr_d = '0;
                    div_cnt_d = '0;
                    div_d     = div;
                    mask_d    = trig_mask;
                    value_d   = trig_value;
                    delay_d   = delay_cnt;
                end
            end
            S_ARMED: begin
                if (strobe && hit) begin
                    if (delay_q == '0) begin
                        // Trigger sample is also the final write.
                        state_d   = S_RD_ISSUE;
                        rd_addr_d = wr_addr_q;
                        sent_d    = '0;
                    end else begin
                        state_d     = S_POST;
                        remaining_d = delay_q - 1'b1;
                    end
                end
            end
            S_POST: begin
                if (strobe) begin
                    if (remaining_q == '0) begin
                        state_d   = S_RD_ISSUE;
                        rd_addr_d = wr_addr_q;
                        sent_d    = '0;
                    end else begin
                        remaining_d = remaining_q - 1'b1;
                    end
                end
            end
            S_RD_ISSUE: begin
                tx_own    = 1'b1;
                rd_ce     = 1'b1;
                started_d = 1'b0;
                state_d   = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                tx_own  = 1'b1;
                state_d = S_TX_REQ;
            end
            S_TX_REQ: begin
                tx_own = 1'b1;
                // A busy seen before our own request belongs to an older frame
                // (e.g. one left running by an abort); only move on once our
                // request has been accepted.
                if (!tx_busy) begin
                    tx_start  = !abort;
                    started_d = 1'b1;
                end else if (started_q) begin
                    state_d = S_TX_BUSY;
                end
            end
            S_TX_BUSY: begin
                tx_own = 1'b1;
                if (!tx_busy) begin
                    sent_d    = sent_q + 1'b1;
                    rd_addr_d = rd_addr_q - 1'b1;
                    state_d   = (sent_q == LAST_SENT) ? S_TX_DONE : S_RD_ISSUE;
                end
            end
            S_TX_DONE: begin
                tx_own  = 1'b1;
                done    = !abort;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge CAP_CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            mask_q      <= '0;
            value_q     <= '0;
            delay_q     <= '0;
            div_cnt_q   <= '0;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            remaining_q <= '0;
            sent_q      <= '0;
            started_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            mask_q      <= mask_d;
            value_q     <= value_d;
            delay_q     <= delay_d;
            div_cnt_q   <= div_cnt_d;
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            remaining_q <= remaining_d;
            sent_q      <= sent_d;
            started_q   <= started_d;
        end
    end

    assign wr_addr = wr_addr_q;
    assign rd_addr = rd_addr_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// tb/tb_capture_sequencer.sv - randomized self-checking bench for capture_sequencer
module tb_capture_sequencer;

    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          arm;
    logic          abort;
    logic          tx_busy = 1'b0;
    logic [7:0]    cap;
    logic [7:0]    trig_mask;
    logic [7:0]    trig_value;
    logic [23:0]   div;
    logic [AW-1:0] delay_cnt;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic          wr_ce, rd_ce, tx_start, tx_own, running, done;

    int vectors = 0;
    int errors  = 0;

    logic [7:0] bram [DEPTH];
    logic [7:0] bram_q = 8'h00;
    logic       bram_init = 1'b0;
    logic [7:0] ref_mem [DEPTH];
    int         u_wait = 0;
    int         busy_left = 0;

    always #5 clk = ~clk;

    capture_sequencer #(.ADDR_W(AW), .DIV_W(24), .CH(8)) dut (
        .CAP_CLK   (clk),
        .RST       (rst),
        .CAP       (cap),
        .arm       (arm),
        .abort     (abort),
        .div       (div),
        .trig_mask (trig_mask),
        .trig_value(trig_value),
        .delay_cnt (delay_cnt),
        .wr_addr   (wr_addr),
        .wr_ce     (wr_ce),
        .rd_addr   (rd_addr),
        .rd_ce     (rd_ce),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .tx_own    (tx_own),
        .running   (running),
        .done      (done)
    );

    // Capture BRAM: outputs are stable at the falling edge, so it is clocked there.
    always @(negedge clk) begin
        if (!bram_init) begin
            for (int i = 0; i < DEPTH; i++) bram[i] <= 8'(i * 37 + 5);
            bram_init <= 1'b1;
        end else begin
            if (wr_ce) bram[wr_addr] <= cap;
            if (rd_ce) bram_q <= bram[rd_addr];
        end
    end

    // UART model: accepts a start 1..3 cycles late, then stays busy 1..10 cycles.
    always @(negedge clk) begin
        if (rst) begin
            u_wait    = 0;
            busy_left = 0;
        end else if (busy_left > 0) begin
            busy_left--;
        end else if (u_wait > 0) begin
            u_wait--;
            if (u_wait == 0) busy_left = $urandom_range(1, 10);
        end else if (tx_start && !tx_busy) begin
            u_wait = $urandom_range(1, 3);
        end
    end

    always @(posedge clk) tx_busy <= (busy_left > 0);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic watch_no_done(input int cycles);
        bit saw = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            if (done) saw = 1'b1;
        end
        check("no_done_after_abort", saw, 0);
        @(posedge clk); #1;
    endtask

    // One acquisition: arm, capture against the model, then readback checks.
    task automatic run(input logic [23:0] d, input logic [7:0] m, input logic [7:0] v,
                       input logic [3:0] dl, input int hold, input bit force_hit,
                       input int abort_post, input int abort_frame);
        int   cnt = 0, n = 0, ti = 0, lastn = 0, k = 0, guard = 0, ex = 0, dones = 0;
        int   dd = int'(d);
        bit   trig = 0, fin = 0, se, pending = 0, prev_start = 0;
        logic [7:0] r;

        div = d; trig_mask = m; trig_value = v; delay_cnt = dl;
        arm = 1'b1; cap = 8'($urandom);
        @(negedge clk);
        check("arm_cycle_wr_ce", wr_ce, 0);
        @(posedge clk); #1;
        arm = 1'b0;

        while (!fin && guard < 4000) begin
            r = 8'($urandom);
            if (cnt < hold)                               cap = (r & ~m) | (~v & m);
            else if (force_hit || $urandom_range(0, 3) == 0) cap = (r & ~m) | (v & m);
            else                                          cap = r;
            abort = (abort_post >= 0) && trig && ((n - ti - 1) == abort_post);
            @(negedge clk);
            check("cap_running", running, 1);
            check("cap_tx_own", tx_own, 0);
            se = ((cnt % (dd + 1)) == dd) && !abort;
            check("wr_ce", wr_ce, se);
            if (se) begin
                check("wr_addr", wr_addr, n % DEPTH);
                ref_mem[n % DEPTH] = cap;
                if (!trig && ((cap ^ v) & m) == 8'h00) begin
                    trig = 1'b1;
                    ti   = n;
                end
                if (trig && n == ti + int'(dl)) begin
                    fin   = 1'b1;
                    lastn = n;
                end
                n++;
            end
            cnt++;
            guard++;
            @(posedge clk); #1;
            if (abort) begin
                abort = 1'b0;
                @(negedge clk);
                check("abort_post_idle", {running, tx_own, wr_ce, rd_ce, tx_start}, 0);
                watch_no_done(40);
                return;
            end
        end
        if (!fin) begin
            check("capture_timeout", 0, 1);
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            return;
        end

        guard = 0;
        while (guard < 600) begin
            cap   = 8'($urandom);
            abort = (abort_frame >= 0) && (k == abort_frame + 1) && tx_busy;
            @(negedge clk);
            if (dones > 0) begin
                check("after_done_idle", {running, tx_own, done}, 0);
                break;
            end
            check("rb_tx_own", tx_own, 1);
            if (tx_start && !prev_start) begin
                ex = (lastn - k) & (DEPTH - 1);
                check("rd_addr_order", rd_addr, ex);
                check("rd_data", bram_q, ref_mem[ex]);
                k++;
            end
            if (tx_busy && k > 0) begin
                check("start_while_busy", tx_start, 0);
                check("rd_addr_stable", rd_addr, (lastn - k + 1) & (DEPTH - 1));
                pending = 1'b0;
            end else if (pending) begin
                check("start_held", tx_start, 1);
            end
            if (tx_start && !tx_busy) pending = 1'b1;
            if (done) begin
                dones++;
                check("bytes_before_done", k, DEPTH);
            end
            prev_start = tx_start;
            guard++;
            @(posedge clk); #1;
            if (abort) begin
                abort = 1'b0;
                @(negedge clk);
                check("abort_rb_idle", {running, tx_own, rd_ce, tx_start}, 0);
                watch_no_done(40);
                return;
            end
        end
        if (dones == 0) check("readback_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'(i * 37 + 5);
        rst = 1'b1; arm = 1'b1; abort = 1'b0; cap = 8'h00;
        div = '0; trig_mask = '0; trig_value = '0; delay_cnt = '0;
        repeat (3) begin
            @(negedge clk);
            check("reset_outputs", {running, wr_ce, rd_ce, tx_start, tx_own, done, wr_addr, rd_addr}, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0; arm = 1'b0;
        repeat (100) begin
            @(negedge clk);
            check("idle_outputs", {running, wr_ce, rd_ce, tx_start, tx_own, done, wr_addr, rd_addr}, 0);
        end
        @(posedge clk); #1;

        run(24'd0, 8'h00, 8'h00, 4'd3,  0,  1'b1, -1, -1);
        run(24'd2, 8'h01, 8'h01, 4'd4,  30, 1'b1, -1, -1);
        run(24'd0, 8'h80, 8'h80, 4'd5,  20, 1'b1, -1, -1);
        run(24'd1, 8'h00, 8'h00, 4'd0,  0,  1'b1, -1, -1);
        run(24'd1, 8'h0c, 8'h04, 4'd10, 6,  1'b1, 3,  -1);
        run(24'd0, 8'h00, 8'h00, 4'd2,  0,  1'b1, -1, 5);
        run(24'd0, 8'h00, 8'h00, 4'd15, 0,  1'b1, -1, -1);
        for (int i = 0; i < 6; i++) begin
            run(24'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                4'($urandom_range(0, 15)), $urandom_range(0, 40), 1'b0, -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
